ram_access_unit: RTL and testbench

//  Bus-side front end for the 8192x32 byte-lane RAM. Accepts one byte/half/word load or

---
 rtl/ram_access_unit.sv | 129 ++++++++++++
 tb/tb_ram_access_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_unit.sv
// Load/store front end for the 8192x32 byte-lane RAM: request decode, lane selects,
// registered-read capture with align/extend, and a one-entry response register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a request when the response slot is free or draining
// RD_WAIT | load issued last cycle; capture ram_dout into the response slot
module ram_access_unit #(
  parameter int ADDR_W = 15,
  parameter int RAM_AW = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_rnw,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [RAM_AW-1:0] ram_address,
  output logic [31:0]       ram_din,
  output logic              ram_rnw,
  output logic [3:0]        ram_cs_b,
  input  logic [31:0]       ram_dout
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        legal;
  logic [3:0]  lane_cs_b;
  logic [1:0]  ld_size;
  logic [1:0]  ld_off;
  logic        ld_signed;
  logic        ld_start;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign req_ready = (state == IDLE) && (!rsp_valid || rsp_ready) && !reset;
  assign accept    = req_valid && req_ready;
  assign ld_start  = accept && legal && req_rnw;

  assign ram_address = req_addr[ADDR_W-1:2];

  always_comb begin
    legal     = 1'b0;
    lane_cs_b = 4'hF;
    ram_din   = req_wdata;
    case (req_size)
      2'b00: begin
        legal     = 1'b1;
        lane_cs_b = ~(4'b0001 << req_addr[1:0]);
        ram_din   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        legal     = !req_addr[0];
        lane_cs_b = req_addr[1] ? 4'b0011 : 4'b1100;
        ram_din   = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        legal     = (req_addr[1:0] == 2'b00);
        lane_cs_b = 4'h0;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal requests still handshake but never touch the RAM.
  assign ram_cs_b = (accept && legal) ? lane_cs_b : 4'hF;
  assign ram_rnw  = !(accept && legal && !req_rnw);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ld_start) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld_byte = ram_dout[{ld_off, 3'b000} +: 8];
    ld_half = ram_dout[{ld_off[1], 4'b0000} +: 16];
    case (ld_size)
      2'b00:   ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = ram_dout;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ld_size   <= 2'b00;
      ld_off    <= 2'b00;
      ld_signed <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ld_start) begin
        ld_size   <= req_size;
        ld_off    <= req_addr[1:0];
        ld_signed <= req_signed;
      end
      // A load only starts once the slot frees, so RD_WAIT can always load it.
      if (state == RD_WAIT) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_rdata <= ld_data;
      end else if (accept && !(legal && req_rnw)) begin
        rsp_valid <= 1'b1;
        rsp_err   <= !legal;
        rsp_rdata <= 32'h0;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_unit.sv
// Directed bench for ram_access_unit with a behavioural byte-lane RAM and a response
// scoreboard fed at request acceptance and drained at response handshake.
module tb_ram_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [14:0] req_addr;
  logic        req_rnw;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [12:0] ram_address;
  logic [31:0] ram_din;
  logic        ram_rnw;
  logic [3:0]  ram_cs_b;
  logic [31:0] ram_dout;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  ram_access_unit #(.ADDR_W(15), .RAM_AW(13)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rnw(req_rnw), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .ram_address(ram_address), .ram_din(ram_din), .ram_rnw(ram_rnw),
    .ram_cs_b(ram_cs_b), .ram_dout(ram_dout)
  );

  // Behavioural RAM: byte-lane writes, registered read data.
  always @(posedge clk) begin
    if (ram_cs_b != 4'hF) begin
      if (!ram_rnw) begin
        for (int b = 0; b < 4; b++)
          if (!ram_cs_b[b]) mem[ram_address][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_address];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  // Drives one request, checks the accept-cycle RAM drive and response latency,
  // and pushes the expected response. Called and returns at posedge+1.
  task automatic issue(input logic rnw, input logic [1:0] size, input logic sgn,
                       input logic [14:0] addr, input logic [31:0] wd,
                       input logic [3:0] exp_cs, input logic exp_err,
                       input logic [31:0] exp_rdata);
    logic        found;
    logic [31:0] exp_din;
    rsp_t        e;
    req_valid  = 1'b1;
    req_rnw    = rnw;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = req_ready;
    end
    chk("accept_timeout", {31'b0, found}, 32'h1);
    case (size)
      2'b00:   exp_din = {4{wd[7:0]}};
      2'b01:   exp_din = {2{wd[15:0]}};
      default: exp_din = wd;
    endcase
    chk("ram_cs_b", {28'b0, ram_cs_b}, {28'b0, exp_cs});
    chk("ram_rnw", {31'b0, ram_rnw}, {31'b0, (rnw || exp_err)});
    chk("ram_address", {19'b0, ram_address}, {19'b0, addr[14:2]});
    if (!rnw) chk("ram_din", ram_din, exp_din);
    e.err = exp_err;
    e.rdata = exp_rdata;
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (rnw && !exp_err) begin
      chk("rd_wait_ready", {31'b0, req_ready}, 32'h0);
      chk("rd_wait_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("rsp_latency", {31'b0, rsp_valid}, 32'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_rnw = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 15'h0010; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'h0);
    chk("reset_cs_b", {28'b0, ram_cs_b}, 32'hF);
    chk("reset_rnw", {31'b0, ram_rnw}, 32'h1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b0;
    @(posedge clk); #1;

    // 1-2: word store, then signed/unsigned byte loads
    issue(1'b0, 2'b10, 1'b0, 15'h0010, 32'hDEADBEEF, 4'b0000, 1'b0, 32'h0);
    issue(1'b1, 2'b00, 1'b1, 15'h0013, 32'h0, 4'b0111, 1'b0, 32'hFFFFFFDE);
    issue(1'b1, 2'b00, 1'b0, 15'h0013, 32'h0, 4'b0111, 1'b0, 32'h000000DE);

    // 3: byte store and aligned loads of the merged word
    issue(1'b0, 2'b00, 1'b0, 15'h0011, 32'h0000005A, 4'b1101, 1'b0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 15'h0010, 32'h0, 4'b0000, 1'b0, 32'hDEAD5AEF);
    issue(1'b1, 2'b01, 1'b0, 15'h0010, 32'h0, 4'b1100, 1'b0, 32'h00005AEF);
    issue(1'b1, 2'b01, 1'b1, 15'h0012, 32'h0, 4'b0011, 1'b0, 32'hFFFFDEAD);

    // 4: misaligned and reserved-size requests leave RAM untouched
    issue(1'b1, 2'b10, 1'b0, 15'h0012, 32'h0, 4'b1111, 1'b1, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 15'h0010, 32'h12345678, 4'b1111, 1'b1, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 15'h0011, 32'h00001234, 4'b1111, 1'b1, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 15'h0010, 32'h0, 4'b0000, 1'b0, 32'hDEAD5AEF);
    issue(1'b0, 2'b01, 1'b0, 15'h0012, 32'h00001234, 4'b0011, 1'b0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 15'h0010, 32'h0, 4'b0000, 1'b0, 32'h12345AEF);

    // 5: back-to-back stores under three cycles of response backpressure
    rsp_ready = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 15'h0020, 32'h11111111, 4'b0000, 1'b0, 32'h0);
    req_valid = 1'b1; req_rnw = 1'b0; req_size = 2'b10; req_addr = 15'h0024;
    req_wdata = 32'h22222222;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
      chk("bp_cs_b", {28'b0, ram_cs_b}, 32'hF);
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("bp_rsp_err", {31'b0, rsp_err}, 32'h0);
      chk("bp_rsp_rdata", rsp_rdata, 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 15'h0024, 32'h22222222, 4'b0000, 1'b0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 15'h0024, 32'h0, 4'b0000, 1'b0, 32'h22222222);

    // 6: reset during RD_WAIT discards the load
    req_valid = 1'b1; req_rnw = 1'b1; req_size = 2'b10; req_addr = 15'h0010;
    @(negedge clk);
    chk("rst_ld_accept", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_cs_b", {28'b0, ram_cs_b}, 32'hF);
    chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_mid_req_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", {31'b0, req_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
      @(negedge clk);
    end
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
